// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner: FSM state encoding and
// the table-width helper used to size the capture register.
package truth_table_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Number of truth-table entries for a block with n inputs.
    function automatic int tbl_w(input int n);
        return 2 ** n;
    endfunction

endpackage

// File: rtl/truth_table_scanner_popcount.sv
// Purely combinational population count, used to report how many
// truth-table entries differ from the golden pattern.
module truth_table_scanner_popcount #(
    parameter int W = 16
) (
    input  logic [W-1:0]       bits,
    output logic [$clog2(W):0] count
);

    // Add up the set bits one at a time; the width holds the all-ones case.
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + ($clog2(W) + 1)'(bits[i]);
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// Exhaustive stimulus/capture stage for a small combinational block.
// Walks stim through every input vector, holds each for SETTLE cycles,
// samples dut_out into table_q and, at the end of the sweep, compares the
// captured table against the golden pattern.
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      dut_out,
    input  logic [tbl_w(N_IN)-1:0]    expected,
    output logic [N_IN-1:0]           stim,
    output logic                      busy,
    output logic                      done,
    output logic [tbl_w(N_IN)-1:0]    table_q,
    output logic                      match,
    output logic [N_IN:0]             mismatch_cnt
);

    localparam int TBL_W = tbl_w(N_IN);
    // A one-cycle settle still needs a one-bit counter.
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [N_IN-1:0]  STIM_MAX  = {N_IN{1'b1}};
    localparam logic [N_IN-1:0]  STIM_ONE  = N_IN'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [N_IN-1:0]     stim_n;
    logic [TBL_W-1:0]    table_n;
    logic [TBL_W-1:0]    table_smp;
    logic                match_n;
    logic [N_IN:0]       mismatch_n;
    logic [N_IN:0]       pop_cnt;

    // Table as it would look once the current vector's result is written;
    // the final verdict must include the last sample taken.
    always_comb begin
        table_smp       = table_q;
        table_smp[stim] = dut_out;
    end

    truth_table_scanner_popcount #(
        .W (TBL_W)
    ) u_popcount (
        .bits  (table_smp ^ expected),
        .count (pop_cnt)
    );

    // Next-state logic: sweep sequencing, table capture and verdict latching.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        stim_n     = stim;
        table_n    = table_q;
        match_n    = match;
        mismatch_n = mismatch_cnt;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n    = ST_SETTLE;
                    cnt_n      = '0;
                    stim_n     = '0;
                    table_n    = '0;
                    match_n    = 1'b0;
                    mismatch_n = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt == CNT_LAST) begin
                    state_n = ST_SAMPLE;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            ST_SAMPLE: begin
                table_n = table_smp;
                if (stim == STIM_MAX) begin
                    state_n    = ST_DONE;
                    match_n    = (table_smp == expected);
                    mismatch_n = pop_cnt;
                end else begin
                    state_n = ST_SETTLE;
                    stim_n  = stim + STIM_ONE;
                    cnt_n   = '0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset overrides everything, even mid-sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            stim         <= '0;
            table_q      <= '0;
            match        <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            stim         <= stim_n;
            table_q      <= table_n;
            match        <= match_n;
            mismatch_cnt <= mismatch_n;
        end
    end

    assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench for truth_table_scanner: a default 4-input instance
// driven by table vectors and random functions, plus a 2-input SETTLE=1
// instance. The reference is the function itself: the captured table must
// equal it, the verdict follows from comparing it with the golden pattern.
module tb_truth_table_scanner;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] func_tbl;
    logic [15:0] expected;
    logic        dut_out;
    logic [3:0]  stim;
    logic        busy;
    logic        done;
    logic [15:0] table_q;
    logic        match;
    logic [4:0]  mismatch_cnt;

    logic        start2;
    logic [3:0]  expected2;
    logic        dut_out2;
    logic [1:0]  stim2;
    logic        busy2;
    logic        done2;
    logic [3:0]  table2;
    logic        match2;
    logic [2:0]  mismatch2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [15:0] func;
        logic [15:0] exp;
        logic        exp_match;
        logic [4:0]  exp_cnt;
    } vec_t;

    vec_t vecs[5];

    assign dut_out  = func_tbl[stim];
    assign dut_out2 = |stim2;

    truth_table_scanner dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .dut_out      (dut_out),
        .expected     (expected),
        .stim         (stim),
        .busy         (busy),
        .done         (done),
        .table_q      (table_q),
        .match        (match),
        .mismatch_cnt (mismatch_cnt)
    );

    truth_table_scanner #(.N_IN(2), .SETTLE(1)) dut2 (
        .clk          (clk),
        .rst          (rst),
        .start        (start2),
        .dut_out      (dut_out2),
        .expected     (expected2),
        .stim         (stim2),
        .busy         (busy2),
        .done         (done2),
        .table_q      (table2),
        .match        (match2),
        .mismatch_cnt (mismatch2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Full sweep on the 4-input instance. The start edge is the reference
    // point for the latency; start can optionally be re-pulsed mid-sweep.
    task automatic applyStimulus(input string tag, input logic [15:0] f, input logic [15:0] e,
                                 input logic exp_match, input logic [4:0] exp_cnt, input int pulse_at);
        int cycles;
        int trace_err;
        func_tbl = f;
        expected = e;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput({tag, "_start_busy"}, {31'd0, busy}, 32'd1);
        checkOutput({tag, "_start_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_start_clear"}, {11'd0, table_q, match, mismatch_cnt}, 32'd0);
        cycles    = 0;
        trace_err = 0;
        while (!done && cycles < 200) begin
            if (cycles < 48 && (stim !== 4'(cycles / 3) || busy !== 1'b1)) trace_err++;
            start = (cycles == pulse_at);
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        checkOutput({tag, "_latency"}, 32'(cycles), 32'd48);
        checkOutput({tag, "_stim_trace"}, 32'(trace_err), 32'd0);
        checkOutput({tag, "_table"}, {16'd0, table_q}, {16'd0, f});
        checkOutput({tag, "_match"}, {31'd0, match}, {31'd0, exp_match});
        checkOutput({tag, "_mcnt"}, {27'd0, mismatch_cnt}, {27'd0, exp_cnt});
        checkOutput({tag, "_end_state"}, {26'd0, busy, stim}, 32'h0000_000f);
        repeat (3) @(posedge clk);
        #1;
        checkOutput({tag, "_hold"}, {15'd0, done, table_q}, {15'd0, 1'b1, f});
    endtask

    initial begin
        vecs[0] = '{"and",     16'h8000, 16'h8000, 1'b1, 5'd0};
        vecs[1] = '{"xor",     16'h6996, 16'h6996, 1'b1, 5'd0};
        vecs[2] = '{"and_c000",16'h8000, 16'hC000, 1'b0, 5'd1};
        vecs[3] = '{"and_7fff",16'h8000, 16'h7FFF, 1'b0, 5'd16};
        vecs[4] = '{"or_ffff", 16'hFFFE, 16'hFFFF, 1'b0, 5'd1};

        rst       = 1'b1;
        start     = 1'b0;
        start2    = 1'b0;
        func_tbl  = 16'h0;
        expected  = 16'h0;
        expected2 = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", {5'd0, stim, busy, done, table_q, match, mismatch_cnt}, 32'd0);
        checkOutput("reset_outputs2", {20'd0, stim2, busy2, done2, table2, match2, mismatch2}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_no_start", {30'd0, busy, done}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].name, vecs[i].func, vecs[i].exp,
                          vecs[i].exp_match, vecs[i].exp_cnt, -1);
        end

        // start re-pulsed at cycle 20 must not disturb the running sweep
        applyStimulus("restart_ignored", 16'h8000, 16'h8000, 1'b1, 5'd0, 20);

        // random functions against related or random golden patterns
        for (int i = 0; i < 8; i++) begin
            logic [15:0] f;
            logic [15:0] e;
            f = 16'($urandom);
            case (i % 3)
                0:       e = f;
                1:       e = f ^ (16'd1 << $urandom_range(0, 15));
                default: e = 16'($urandom);
            endcase
            applyStimulus($sformatf("rand%0d", i), f, e, (f == e), 5'($countones(f ^ e)), -1);
        end

        // reset in the middle of a sweep
        func_tbl = 16'h6996;
        expected = 16'h6996;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("mid_reset_outputs", {5'd0, stim, busy, done, table_q, match, mismatch_cnt}, 32'd0);
        begin
            int active;
            active = 0;
            for (int c = 0; c < 100; c++) begin
                @(posedge clk); #1;
                if (done || busy) active++;
            end
            checkOutput("idle_after_reset", 32'(active), 32'd0);
        end

        // small instance: 2-input OR, one settle cycle
        for (int k = 0; k < 2; k++) begin
            int cyc;
            logic [3:0] e2;
            e2        = (k == 0) ? 4'hE : 4'h1;
            expected2 = e2;
            start2    = 1'b1;
            @(posedge clk); #1;
            start2 = 1'b0;
            cyc    = 0;
            while (!done2 && cyc < 100) begin
                if (busy2 && done2) cyc = 1000;
                @(posedge clk); #1;
                cyc++;
            end
            checkOutput($sformatf("small%0d_latency", k), 32'(cyc), 32'd8);
            checkOutput($sformatf("small%0d_table", k), {28'd0, table2}, 32'hE);
            checkOutput($sformatf("small%0d_match", k), {31'd0, match2}, {31'd0, (e2 == 4'hE)});
            checkOutput($sformatf("small%0d_mcnt", k), {29'd0, mismatch2}, 32'($countones(e2 ^ 4'hE)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
